life_controller: RTL and testbench

LIFE_CONTROLLER -- requirements
Module: life_controller

---
 rtl/life_controller.sv | 159 +++++++++++++++
 tb/tb_life_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/life_controller.sv
// Game-of-Life controller: button-driven cell editing, timed generation stepping in PLAY,
// and clear/step/write strobes toward the grid datapath. All outputs are registered.
module life_controller #(
    parameter int unsigned GEN_PERIOD = 4,
    parameter int unsigned NCELLS     = 64,
    localparam int unsigned IW        = $clog2(NCELLS)
) (
    input  logic          clka,
    input  logic          reset,
    input  logic          btn0,
    input  logic          btn1,
    input  logic          run,
    input  logic          stop,
    output logic [1:0]    state,
    output logic [IW-1:0] cell_idx,
    output logic          cell_we,
    output logic          cell_val,
    output logic          clr,
    output logic          step,
    output logic [7:0]    gen_count
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StEdit = 2'b01,
        StPlay = 2'b10,
        StHalt = 2'b11
    } state_e;

    localparam logic [7:0]    LastTick = 8'(GEN_PERIOD - 1);
    localparam logic [IW-1:0] IdxOne   = IW'(1);

    state_e        state_q, state_d;
    logic          btn0_q, btn1_q;
    logic          rise0, rise1, any_rise;
    logic [7:0]    timer_q, timer_d;
    logic [IW-1:0] cell_idx_d;
    logic          cell_we_d, cell_val_d, clr_d, step_d;
    logic [7:0]    gen_count_d;
    logic          resume;

    assign rise0    = btn0 & ~btn0_q;
    assign rise1    = btn1 & ~btn1_q;
    assign any_rise = rise0 | rise1;
    assign resume   = run & ~stop;
    assign state    = state_q;

    // State register
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop always wins over run
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (any_rise) state_d = StEdit;
            StEdit: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (run) begin
                    state_d = StPlay;
                end
            end
            StPlay: if (stop) state_d = StHalt;
            StHalt: begin
                if (resume) begin
                    state_d = StPlay;
                end else if (any_rise) begin
                    state_d = StEdit;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        cell_we_d   = 1'b0;
        clr_d       = 1'b0;
        step_d      = 1'b0;
        cell_val_d  = cell_val;
        gen_count_d = gen_count;
        timer_d     = timer_q;
        // Cursor advances in the cycle after each write strobe
        cell_idx_d  = cell_we ? cell_idx + IdxOne : cell_idx;
        case (state_q)
            StIdle: begin
                if (any_rise) begin
                    clr_d       = 1'b1;
                    cell_idx_d  = '0;
                    gen_count_d = '0;
                end
            end
            StEdit: begin
                if (stop) begin
                    timer_d = timer_q;
                end else if (run) begin
                    timer_d = '0;
                end else if (any_rise && !cell_we) begin
                    // A back-to-back rise is dropped so the write strobe never stretches
                    cell_we_d  = 1'b1;
                    cell_val_d = rise0;
                end
            end
            StPlay: begin
                if (!stop) begin
                    if (timer_q == LastTick) begin
                        timer_d     = '0;
                        step_d      = 1'b1;
                        gen_count_d = (gen_count == 8'hFF) ? gen_count : gen_count + 8'd1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            StHalt: begin
                if (resume) begin
                    timer_d = '0;
                end else if (any_rise) begin
                    clr_d       = 1'b1;
                    cell_idx_d  = '0;
                    gen_count_d = '0;
                end
            end
            default: timer_d = '0;
        endcase
    end

    // Registered outputs, timer and button history
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            btn0_q    <= 1'b0;
            btn1_q    <= 1'b0;
            timer_q   <= '0;
            cell_idx  <= '0;
            cell_we   <= 1'b0;
            cell_val  <= 1'b0;
            clr       <= 1'b0;
            step      <= 1'b0;
            gen_count <= '0;
        end else begin
            btn0_q    <= btn0;
            btn1_q    <= btn1;
            timer_q   <= timer_d;
            cell_idx  <= cell_idx_d;
            cell_we   <= cell_we_d;
            cell_val  <= cell_val_d;
            clr       <= clr_d;
            step      <= step_d;
            gen_count <= gen_count_d;
        end
    end

endmodule

// File: tb/tb_life_controller.sv
// Directed self-checking bench for life_controller (GEN_PERIOD=4, NCELLS=64).
module tb_life_controller;

    logic       clka;
    logic       reset;
    logic       btn0, btn1, run, stop;
    logic [1:0] state;
    logic [5:0] cell_idx;
    logic       cell_we, cell_val, clr, step;
    logic [7:0] gen_count;

    int tests;
    int fails;

    life_controller #(
        .GEN_PERIOD(4),
        .NCELLS    (64)
    ) dut (
        .clka     (clka),
        .reset    (reset),
        .btn0     (btn0),
        .btn1     (btn1),
        .run      (run),
        .stop     (stop),
        .state    (state),
        .cell_idx (cell_idx),
        .cell_we  (cell_we),
        .cell_val (cell_val),
        .clr      (clr),
        .step     (step),
        .gen_count(gen_count)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clka);
        #1;
    endtask

    // One edit write: rise on the given buttons, then release
    task automatic press(input logic b0, input logic b1, input int idx, input logic val);
        btn0 = b0;
        btn1 = b1;
        cyc();
        check("we_strobe", cell_we, 1);
        check("we_idx", cell_idx, idx);
        check("we_val", cell_val, val);
        check("we_state", state, 1);
        btn0 = 1'b0;
        btn1 = 1'b0;
        cyc();
        check("we_single", cell_we, 0);
        check("idx_inc", cell_idx, (idx + 1) % 64);
        check("val_hold", cell_val, val);
    endtask

    initial begin
        logic [6:0] vals;
        tests = 0;
        fails = 0;
        btn0  = 1'b0;
        btn1  = 1'b0;
        run   = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) cyc();
        check("rst_state", state, 0);
        check("rst_idx", cell_idx, 0);
        check("rst_gen", gen_count, 0);
        check("rst_strobes", {cell_we, cell_val, clr, step}, 0);
        reset = 1'b0;

        // IDLE ignores run/stop
        run = 1'b1;
        cyc();
        check("idle_run", state, 0);
        run = 1'b0;

        // Enter EDIT with a clear, no write
        btn0 = 1'b1;
        cyc();
        check("entry_state", state, 1);
        check("entry_clr", clr, 1);
        check("entry_we", cell_we, 0);
        check("entry_gen", gen_count, 0);
        check("entry_idx", cell_idx, 0);
        btn0 = 1'b0;
        cyc();
        check("clr_once", clr, 0);
        check("entry_nowe", cell_we, 0);

        // Writes 0..6 with 1,0,0,0,0,0,1
        vals = 7'b1000001;
        for (int i = 0; i < 7; i++) begin
            press(vals[i], ~vals[i], i, vals[i]);
        end
        check("idx_seven", cell_idx, 7);

        // Walk to 63, wrap, then simultaneous rise
        for (int i = 7; i < 63; i++) begin
            press(1'b0, 1'b1, i, 1'b0);
        end
        press(1'b0, 1'b1, 63, 1'b0);
        check("wrap_state", state, 1);
        press(1'b1, 1'b1, 0, 1'b1);

        // Held button gives exactly one write
        btn0 = 1'b1;
        cyc();
        check("held_we1", cell_we, 1);
        cyc();
        check("held_we2", cell_we, 0);
        cyc();
        check("held_we3", cell_we, 0);
        check("held_idx", cell_idx, 2);
        btn0 = 1'b0;
        cyc();

        // EDIT stop -> IDLE, holding cursor
        stop = 1'b1;
        run  = 1'b1;
        cyc();
        check("edit_stop", state, 0);
        check("stop_idx", cell_idx, 2);
        stop = 1'b0;
        run  = 1'b0;
        btn1 = 1'b1;
        cyc();
        check("reedit", state, 1);
        check("reedit_idx", cell_idx, 0);
        btn1 = 1'b0;
        cyc();

        // run with simultaneous rise: rise discarded, PLAY entered
        run  = 1'b1;
        btn0 = 1'b1;
        cyc();
        check("play_entry", state, 2);
        check("play_nowe", cell_we, 0);
        run  = 1'b0;
        btn0 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            btn1 = k[0];
            cyc();
            check("play_step", step, (k % 4 == 0) ? 1 : 0);
            check("play_we", cell_we, 0);
        end
        btn1 = 1'b0;
        check("play_gen3", gen_count, 3);
        check("play_state", state, 2);

        // Stop in the cycle a step is due
        repeat (3) cyc();
        stop = 1'b1;
        cyc();
        check("halt_state", state, 3);
        check("halt_nostep", step, 0);
        check("halt_gen", gen_count, 3);
        run = 1'b1;
        cyc();
        check("halt_stop_prio", state, 3);
        stop = 1'b0;
        cyc();
        check("resume_state", state, 2);
        run = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("resume_step", step, (k == 4) ? 1 : 0);
        end
        check("resume_gen", gen_count, 4);

        // HALT + rise -> EDIT with clear
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        btn1 = 1'b1;
        cyc();
        check("halt_edit", state, 1);
        check("halt_clr", clr, 1);
        check("halt_gen0", gen_count, 0);
        check("halt_idx0", cell_idx, 0);
        btn1 = 1'b0;
        cyc();

        // Saturation
        run = 1'b1;
        cyc();
        run = 1'b0;
        repeat (4 * 256) cyc();
        check("sat_gen", gen_count, 255);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("sat_step", step, (k == 4) ? 1 : 0);
        end
        check("sat_hold", gen_count, 255);

        // Async reset mid-PLAY with btn0 held
        repeat (2) cyc();
        btn0 = 1'b1;
        cyc();
        check("play_ignore_btn", state, 2);
        #2 reset = 1'b1;
        #1;
        check("async_state", state, 0);
        check("async_gen", gen_count, 0);
        check("async_strobes", {cell_we, cell_val, clr, step}, 0);
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        check("post_rst_state", state, 1);
        check("post_rst_clr", clr, 1);
        cyc();
        check("post_rst_clr1", clr, 0);
        check("post_rst_we", cell_we, 0);
        btn0 = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
